load_use_hazard_unit: RTL and testbench

//  Tracks destination-register info down ID/EX -> EX/MEM -> MEM/WB and detects load-use hazards.
//  On a hazard it freezes PC and IF/ID and injects a bubble into ID/EX.
//  Its EX_MEM_*/MEM_WB_* outputs drive data_forwarding_unit directly.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/pipe_stage_reg.sv | 19 +
 rtl/load_use_hazard_unit.sv | 118 +++++++++++
 tb/tb_load_use_hazard_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard unit: per-stage destination info,
// the bubble encoding and the stall FSM states.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

  typedef enum logic {RUN, STALL} state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage of destination-register tracking; bubble wins over load.
module pipe_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  stage_info_t d,
  output stage_info_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n)      q <= BUBBLE;
    else if (bubble) q <= BUBBLE;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection with ID/EX -> EX/MEM -> MEM/WB destination tracking.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module load_use_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = hazard_pkg::REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W           = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] IF_ID_rsA,
  input  logic [REG_ADDR_W-1:0] IF_ID_rsB,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] ID_EX_Rd,
  output logic [REG_ADDR_W-1:0] EX_MEM_Rd,
  output logic                  EX_MEM_RegWrite,
  output logic [REG_ADDR_W-1:0] MEM_WB_Rd,
  output logic                  MEM_WB_RegWrite,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  IF_ID_write
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0]    stall_count
`endif
);

  localparam int STAGES = 3;

  if (REG_ADDR_W != hazard_pkg::REG_ADDR_W) begin : g_bad_w
    $error("REG_ADDR_W must match hazard_pkg::REG_ADDR_W");
  end
  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_n
    $error("LOAD_STALL_CYCLES must be in 1..7");
  end

  stage_info_t [STAGES-1:0] st_in, st_q;
  stage_info_t dec_info;
  state_t      state;
  logic [2:0]  cnt;
  logic        hazard, id_bubble;

  // r0 is never a real destination, so its write/load flags are dropped on capture
  always_comb begin
    dec_info.rd        = id_rd;
    dec_info.reg_write = id_reg_write & (id_rd != '0);
    dec_info.mem_read  = id_mem_read  & (id_rd != '0);
  end

  assign hazard = id_valid & st_q[0].mem_read & (st_q[0].rd != '0) &
                  ((st_q[0].rd == IF_ID_rsA) | (st_q[0].rd == IF_ID_rsB));

  assign stall       = ~flush & ((state == STALL) | hazard);
  assign pc_write    = ~stall;
  assign IF_ID_write = ~stall;
  assign id_bubble   = stall | flush | ~id_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_src
      assign st_in[i] = dec_info;
    end else begin : g_src
      assign st_in[i] = st_q[i-1];
    end
    pipe_stage_reg u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (1'b1),
      .bubble ((i == 0) ? id_bubble : 1'b0),
      .d      (st_in[i]),
      .q      (st_q[i])
    );
  end

  // cnt holds the stall cycles still owed after the current one
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: if (hazard) begin
          cnt   <= 3'(LOAD_STALL_CYCLES - 1);
          state <= (LOAD_STALL_CYCLES == 1) ? RUN : STALL;
        end
        STALL: if (cnt <= 3'd1) begin
          cnt   <= '0;
          state <= RUN;
        end else begin
          cnt   <= cnt - 3'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                       stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
`endif

  assign ID_EX_Rd        = st_q[0].rd;
  assign EX_MEM_Rd       = st_q[1].rd;
  assign EX_MEM_RegWrite = st_q[1].reg_write;
  assign MEM_WB_Rd       = st_q[2].rd;
  assign MEM_WB_RegWrite = st_q[2].reg_write;

  logic unused_mem_read;
  assign unused_mem_read = st_q[1].mem_read | st_q[2].mem_read;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed-vector scoreboard bench: two units (1-cycle and 3-cycle stall) share stimulus.
module tb_load_use_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, id_valid = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [4:0] rs_a = '0, rs_b = '0, id_rd = '0;

  logic [1:0][4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic [1:0]      ex_mem_rw, mem_wb_rw, stall, pc_write, if_id_write;
`ifdef HAZARD_STALL_CNT_EN
  logic [1:0][15:0] stall_count;
`endif

  load_use_hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .IF_ID_rsA(rs_a), .IF_ID_rsB(rs_b),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .ID_EX_Rd(id_ex_rd[0]), .EX_MEM_Rd(ex_mem_rd[0]), .EX_MEM_RegWrite(ex_mem_rw[0]),
    .MEM_WB_Rd(mem_wb_rd[0]), .MEM_WB_RegWrite(mem_wb_rw[0]), .stall(stall[0]),
    .pc_write(pc_write[0]), .IF_ID_write(if_id_write[0])
`ifdef HAZARD_STALL_CNT_EN
    , .stall_count(stall_count[0])
`endif
  );

  load_use_hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .IF_ID_rsA(rs_a), .IF_ID_rsB(rs_b),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .ID_EX_Rd(id_ex_rd[1]), .EX_MEM_Rd(ex_mem_rd[1]), .EX_MEM_RegWrite(ex_mem_rw[1]),
    .MEM_WB_Rd(mem_wb_rd[1]), .MEM_WB_RegWrite(mem_wb_rw[1]), .stall(stall[1]),
    .pc_write(pc_write[1]), .IF_ID_write(if_id_write[1])
`ifdef HAZARD_STALL_CNT_EN
    , .stall_count(stall_count[1])
`endif
  );

  // sel: -1 no check, 0 = 1-cycle unit, 1 = 3-cycle unit
  typedef struct {
    logic rst_n, v; logic [4:0] a, b, rd; logic rw, mr, fl;
    int sel; logic stall; logic [4:0] idex, exm; logic exw; logic [4:0] mwb; logic mww; int cnt;
    int row;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;
  int n_chk = 0, n_fail = 0;

  function automatic vec_t mk(logic r, logic v, int a, int b, int rd, logic rw, logic mr, logic fl,
                              int sel, logic st, int idex, int exm, logic exw, int mwb, logic mww, int cnt);
    vec_t t;
    t.rst_n = r; t.v = v; t.a = 5'(a); t.b = 5'(b); t.rd = 5'(rd); t.rw = rw; t.mr = mr; t.fl = fl;
    t.sel = sel; t.stall = st; t.idex = 5'(idex); t.exm = 5'(exm); t.exw = exw;
    t.mwb = 5'(mwb); t.mww = mww; t.cnt = cnt; t.row = 0;
    return t;
  endfunction

  task automatic cmp(input int row, input int sel, input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d dut%0d %s: got %0d expected %0d", row, sel, name, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.sel >= 0) begin
        cmp(e.row, e.sel, "stall",           int'(stall[e.sel]),       int'(e.stall));
        cmp(e.row, e.sel, "pc_write",        int'(pc_write[e.sel]),    int'(!e.stall));
        cmp(e.row, e.sel, "IF_ID_write",     int'(if_id_write[e.sel]), int'(!e.stall));
        cmp(e.row, e.sel, "ID_EX_Rd",        int'(id_ex_rd[e.sel]),    int'(e.idex));
        cmp(e.row, e.sel, "EX_MEM_Rd",       int'(ex_mem_rd[e.sel]),   int'(e.exm));
        cmp(e.row, e.sel, "EX_MEM_RegWrite", int'(ex_mem_rw[e.sel]),   int'(e.exw));
        cmp(e.row, e.sel, "MEM_WB_Rd",       int'(mem_wb_rd[e.sel]),   int'(e.mwb));
        cmp(e.row, e.sel, "MEM_WB_RegWrite", int'(mem_wb_rw[e.sel]),   int'(e.mww));
`ifdef HAZARD_STALL_CNT_EN
        cmp(e.row, e.sel, "stall_count",     int'(stall_count[e.sel]), e.cnt);
`endif
      end
    end
  end

  initial begin
    //              rst v  A  B  rd rw mr fl  sel st idex exm exw mwb mww cnt
    // 1-cycle unit: load-use, non-load forwarding, r0 load, hazard+flush
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 7, 1, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 7, 3, 8, 1, 0, 0,  0, 1, 7,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 7, 3, 8, 1, 0, 0,  0, 0, 0,  7, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8, 0, 7, 1, 0, 0,  0, 0, 8,  0, 0, 7, 1, 1));
    vecs.push_back(mk(1, 1, 7, 7, 9, 1, 0, 0,  0, 0, 7,  8, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0,  0, 0, 9,  7, 1, 8, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  9, 1, 7, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 9, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4, 0, 6, 1, 0, 1,  0, 0, 4,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4, 0, 6, 1, 0, 0,  0, 0, 0,  4, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6,  0, 0, 4, 1, 1));
    // 3-cycle unit: rsB hazard stalls exactly 3 cycles, then reset during STALL
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 5, 1, 1, 0,  1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 5,10, 1, 0, 0,  1, 1, 5,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 5,10, 1, 0, 0,  1, 1, 0,  5, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 5,10, 1, 0, 0,  1, 1, 0,  0, 0, 5, 1, 2));
    vecs.push_back(mk(1, 1, 1, 5,10, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 0,10,  0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 3, 1, 1, 0,  1, 0, 0, 10, 1, 0, 0, 3));
    vecs.push_back(mk(1, 1, 3, 0,11, 1, 0, 0,  1, 1, 3,  0, 0,10, 1, 3));
    vecs.push_back(mk(0, 1, 3, 0,11, 1, 0, 0,  1, 1, 0,  3, 1, 0, 0, 4));
    vecs.push_back(mk(1, 1, 3, 0,11, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 0,11,  0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      @(posedge clk);
      #1;
      t = vecs[i];
      t.row = i;
      rst_n = t.rst_n; id_valid = t.v; rs_a = t.a; rs_b = t.b; id_rd = t.rd;
      id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl;
      exp_q.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp(-1, -1, "scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
